// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: instruction classes, field positions and word width shared by
// the instruction encoder and the decode stage.
package cpu_isa_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 9;
    localparam int RS_HI   = 8;
    localparam int RS_LO   = 6;
    localparam int IMM_HI  = 5;
    localparam int IMM_LO  = 0;

    typedef enum logic [1:0] {
        CLS_LDA = 2'b00,
        CLS_STA = 2'b01,
        CLS_IMM = 2'b10,
        CLS_BAF = 2'b11
    } instr_class_e;

    typedef logic [INSTR_W-1:0] instr_word_t;

endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: packs instruction fields into a 16-bit word and flags
// field combinations the ISA does not allow.
module instr_field_pack
    import cpu_isa_pkg::*;
(
    input  logic [1:0]  i_class,
    input  logic [1:0]  i_alufunc,
    input  logic [2:0]  i_rd,
    input  logic [2:0]  i_rs,
    input  logic [5:0]  i_imm,
    output instr_word_t o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word                  = '0;
        o_word[OPC_HI:OPC_LO+2] = i_class;
        o_word[OPC_LO+1:OPC_LO] = i_alufunc;
        o_word[RD_HI:RD_LO]     = i_rd;
        o_word[RS_HI:RS_LO]     = i_rs;
        o_word[IMM_HI:IMM_LO]   = i_imm;
        // r0 is hard-wired, so anything that writes it is rejected
        o_illegal = ((i_class == CLS_LDA || i_class == CLS_IMM) && i_rd == 3'd0)
                  || (i_class == CLS_BAF && i_alufunc != 2'b00)
                  || (i_class == CLS_STA && i_rd != 3'd0);
    end

endmodule

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: accepts field sets, encodes and legality-checks them and
// writes legal words sequentially into IMEM. Define CHECKSUM_EN for a running XOR.
module instr_stream_encoder
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [1:0]        i_class,
    input  logic [1:0]        i_alufunc,
    input  logic [2:0]        i_rd,
    input  logic [2:0]        i_rs,
    input  logic [5:0]        i_imm,
    input  logic              i_last,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [15:0]       o_imem_wdata,
    output logic              o_err,
    output logic              o_done,
    output logic              o_full,
    output logic [15:0]       o_checksum
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST_A = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
    instr_word_t       wdata_q, wdata_d, word;
    logic              we_q, we_d, err_q, err_d, full_q, full_d;
    logic              illegal, fire, wr, at_end;

    instr_field_pack u_pack (
        .i_class   (i_class),
        .i_alufunc (i_alufunc),
        .i_rd      (i_rd),
        .i_rs      (i_rs),
        .i_imm     (i_imm),
        .o_word    (word),
        .o_illegal (illegal)
    );

    assign o_ready = (state_q == S_LOAD);
    assign fire    = i_valid & o_ready & ~i_start;
    assign wr      = fire & ~illegal;
    assign at_end  = (ptr_q == LAST_A);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        full_d  = full_q;
        we_d    = wr;
        err_d   = fire & illegal;
        addr_d  = wr ? ptr_q : addr_q;
        wdata_d = wr ? word : wdata_q;
        if (i_start) begin
            state_d = S_LOAD;
            ptr_d   = BASE_A;
            full_d  = 1'b0;
        end else if (fire) begin
            // pointer saturates at the top address; the session ends there
            if (wr) begin
                ptr_d  = at_end ? ptr_q : ptr_q + 1'b1;
                full_d = full_q | at_end;
            end
            if (i_last || (wr && at_end)) state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= BASE_A;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
            full_q  <= full_d;
        end
    end

    assign o_imem_we    = we_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_wdata = wdata_q;
    assign o_err        = err_q;
    assign o_full       = full_q;
    assign o_done       = (state_q == S_DONE);

`ifdef CHECKSUM_EN
    logic [15:0] chk_q, chk_d;

    always_comb chk_d = i_start ? 16'h0000 : (we_q ? chk_q ^ wdata_q : chk_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chk_q <= 16'h0000;
        else          chk_q <= chk_d;
    end

    assign o_checksum = chk_q;
`else
    assign o_checksum = 16'h0000;
`endif

endmodule
